// File: rtl/lpif_gearbox_pkg.sv
// Shared field layout, flit control struct and ratio helper for the LPIF asymmetric gearbox.
package lpif_gearbox_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned PROTID_W = 2;
    localparam int unsigned CRC_W    = 2;
    localparam int unsigned CTL_W    = STATE_W + PROTID_W + 1 + CRC_W + 1 + 1;

    localparam int unsigned OFF_STATE  = 0;
    localparam int unsigned OFF_PROTID = OFF_STATE + STATE_W;
    localparam int unsigned OFF_DATA   = OFF_PROTID + PROTID_W;

    // Fields above the data field, relative to the first bit after data
    localparam int unsigned REL_DVALID    = 0;
    localparam int unsigned REL_CRC       = REL_DVALID + 1;
    localparam int unsigned REL_CRC_VALID = REL_CRC + CRC_W;
    localparam int unsigned REL_VALID     = REL_CRC_VALID + 1;

    typedef struct packed {
        logic                valid;
        logic                crc_valid;
        logic [CRC_W-1:0]    crc;
        logic                dvalid;
        logic [PROTID_W-1:0] protid;
        logic [STATE_W-1:0]  state;
    } flit_ctl_t;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_UNPACK = 1'b1
    } rx_state_e;

    function automatic int unsigned eff_ratio(input logic gen2, input int unsigned asym);
        int unsigned r;
        if (gen2) r = asym;
        else if (asym >= 2) r = asym / 2;
        else r = 1;
        return r;
    endfunction

endpackage

// File: rtl/lpif_gearbox_rx_unpack.sv
// RX side: captures wide FIFO words and replays their slots one flit per cycle.
// With LPIF_GEARBOX_PARITY_EN each slot's even parity is checked as it is replayed.
module lpif_gearbox_rx_unpack
    import lpif_gearbox_pkg::*;
#(
    parameter int unsigned ASYM_RATIO = 2,
    parameter int unsigned FLIT_W     = 75,
    parameter int unsigned SLOT_W     = 75,
    parameter int unsigned WORD_W     = 150,
    parameter int unsigned CNT_W      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gen2,
    input  logic              mode_chg,
    input  logic [WORD_W-1:0] word,
    input  logic              word_vld,
    output logic              rdy_c,
    output logic              busy_c,
    output logic [FLIT_W-1:0] flit_q
`ifdef LPIF_GEARBOX_PARITY_EN
    ,
    output logic              par_err
`endif
);

    rx_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] buf_q;
    logic [CNT_W-1:0]  last_c;
    logic [SLOT_W-1:0] slot_c;

    assign last_c = CNT_W'(eff_ratio(gen2, ASYM_RATIO) - 1);
    assign slot_c = buf_q[32'(cnt) * SLOT_W +: SLOT_W];
    assign busy_c = (state == RX_UNPACK);
    // Pop on the last replayed slot too, so back-to-back words have no bubble
    assign rdy_c  = !mode_chg && ((state == RX_IDLE) || (cnt == last_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            buf_q   <= '0;
            flit_q  <= '0;
`ifdef LPIF_GEARBOX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            flit_q[FLIT_W-1] <= 1'b0;
            if (mode_chg) begin
                state <= RX_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (word_vld) begin
                            buf_q <= word;
                            cnt   <= '0;
                            state <= RX_UNPACK;
                        end
                    end
                    RX_UNPACK: begin
                        flit_q <= slot_c[FLIT_W-1:0];
`ifdef LPIF_GEARBOX_PARITY_EN
                        if (^slot_c) par_err <= 1'b1;
`endif
                        if (cnt == last_c) begin
                            cnt <= '0;
                            if (word_vld) buf_q <= word;
                            else state <= RX_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/lpif_txrx_asym_gearbox.sv
// LPIF <-> logic-link FIFO gearbox: packs eff_ratio downstream flits per TX word, unpacks RX words.
// Optional per-slot even parity with LPIF_GEARBOX_PARITY_EN.
module lpif_txrx_asym_gearbox
    import lpif_gearbox_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ASYM_RATIO = 2,
    parameter int unsigned FLIT_W     = DATA_W + CTL_W,
`ifdef LPIF_GEARBOX_PARITY_EN
    parameter int unsigned WORD_W     = (FLIT_W + 1) * ASYM_RATIO
`else
    parameter int unsigned WORD_W     = FLIT_W * ASYM_RATIO
`endif
) (
    input  logic                clk_wr,
    input  logic                rst_wr_n,
    input  logic                m_gen2_mode,
    input  logic [STATE_W-1:0]  dstrm_state,
    input  logic [PROTID_W-1:0] dstrm_protid,
    input  logic [DATA_W-1:0]   dstrm_data,
    input  logic                dstrm_dvalid,
    input  logic [CRC_W-1:0]    dstrm_crc,
    input  logic                dstrm_crc_valid,
    input  logic                dstrm_valid,
    input  logic                tx_flush,
    output logic [WORD_W-1:0]   txfifo_downstream_data,
    output logic                txfifo_downstream_vld,
    input  logic [WORD_W-1:0]   rxfifo_upstream_data,
    input  logic                rxfifo_upstream_vld,
    output logic                rxfifo_upstream_rdy,
    output logic [STATE_W-1:0]  ustrm_state,
    output logic [PROTID_W-1:0] ustrm_protid,
    output logic [DATA_W-1:0]   ustrm_data,
    output logic                ustrm_dvalid,
    output logic [CRC_W-1:0]    ustrm_crc,
    output logic                ustrm_crc_valid,
    output logic                ustrm_valid
`ifdef LPIF_GEARBOX_PARITY_EN
    ,
    output logic                rx_parity_err
`endif
);

`ifdef LPIF_GEARBOX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned SLOT_W        = FLIT_W + PAR_W;
    localparam int unsigned CNT_W         = (ASYM_RATIO > 1) ? $clog2(ASYM_RATIO) : 1;
    localparam int unsigned OFF_DVALID    = OFF_DATA + DATA_W + REL_DVALID;
    localparam int unsigned OFF_CRC       = OFF_DATA + DATA_W + REL_CRC;
    localparam int unsigned OFF_CRC_VALID = OFF_DATA + DATA_W + REL_CRC_VALID;
    localparam int unsigned OFF_VALID     = OFF_DATA + DATA_W + REL_VALID;

    logic              gen2_q;
    logic [CNT_W-1:0]  tx_cnt;
    logic [WORD_W-1:0] tx_buf;
    logic [WORD_W-1:0] word_c;
    logic [FLIT_W-1:0] d_flit_c;
    logic [SLOT_W-1:0] d_slot_c;
    logic [CNT_W-1:0]  last_c;
    logic              emit_c;
    logic              mode_chg_c;
    logic              rx_busy_c;
    logic [FLIT_W-1:0] rx_flit;
    flit_ctl_t         u_ctl;

    assign last_c     = CNT_W'(eff_ratio(m_gen2_mode, ASYM_RATIO) - 1);
    // A ratio change only matters while a word is partly built or being replayed
    assign mode_chg_c = (m_gen2_mode != gen2_q) && ((tx_cnt != '0) || rx_busy_c);

    // Downstream flit into slot layout and merged into the word under construction
    always_comb begin
        d_flit_c = '0;
        d_flit_c[OFF_STATE +: STATE_W]   = dstrm_state;
        d_flit_c[OFF_PROTID +: PROTID_W] = dstrm_protid;
        d_flit_c[OFF_DATA +: DATA_W]     = dstrm_data;
        d_flit_c[OFF_DVALID]             = dstrm_dvalid;
        d_flit_c[OFF_CRC +: CRC_W]       = dstrm_crc;
        d_flit_c[OFF_CRC_VALID]          = dstrm_crc_valid;
        d_flit_c[OFF_VALID]              = dstrm_valid;
`ifdef LPIF_GEARBOX_PARITY_EN
        d_slot_c = {^d_flit_c, d_flit_c};
`else
        d_slot_c = d_flit_c;
`endif
        word_c = tx_buf;
        if (dstrm_valid) word_c[32'(tx_cnt) * SLOT_W +: SLOT_W] = d_slot_c;
        emit_c = (dstrm_valid && (tx_cnt == last_c))
              || (tx_flush && ((tx_cnt != '0) || dstrm_valid));
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            gen2_q                 <= 1'b0;
            tx_cnt                 <= '0;
            tx_buf                 <= '0;
            txfifo_downstream_data <= '0;
            txfifo_downstream_vld  <= 1'b0;
        end else begin
            gen2_q                <= m_gen2_mode;
            txfifo_downstream_vld <= 1'b0;
            if (mode_chg_c) begin
                tx_cnt <= '0;
                tx_buf <= '0;
            end else if (emit_c) begin
                txfifo_downstream_data <= word_c;
                txfifo_downstream_vld  <= 1'b1;
                tx_cnt                 <= '0;
                tx_buf                 <= '0;
            end else if (dstrm_valid) begin
                tx_buf <= word_c;
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    lpif_gearbox_rx_unpack #(
        .ASYM_RATIO (ASYM_RATIO),
        .FLIT_W     (FLIT_W),
        .SLOT_W     (SLOT_W),
        .WORD_W     (WORD_W),
        .CNT_W      (CNT_W)
    ) u_rx (
        .clk      (clk_wr),
        .rst_n    (rst_wr_n),
        .gen2     (m_gen2_mode),
        .mode_chg (mode_chg_c),
        .word     (rxfifo_upstream_data),
        .word_vld (rxfifo_upstream_vld),
        .rdy_c    (rxfifo_upstream_rdy),
        .busy_c   (rx_busy_c),
        .flit_q   (rx_flit)
`ifdef LPIF_GEARBOX_PARITY_EN
        ,
        .par_err  (rx_parity_err)
`endif
    );

    always_comb begin
        u_ctl.state     = rx_flit[OFF_STATE +: STATE_W];
        u_ctl.protid    = rx_flit[OFF_PROTID +: PROTID_W];
        u_ctl.dvalid    = rx_flit[OFF_DVALID];
        u_ctl.crc       = rx_flit[OFF_CRC +: CRC_W];
        u_ctl.crc_valid = rx_flit[OFF_CRC_VALID];
        u_ctl.valid     = rx_flit[OFF_VALID];
    end

    assign ustrm_state     = u_ctl.state;
    assign ustrm_protid    = u_ctl.protid;
    assign ustrm_data      = rx_flit[OFF_DATA +: DATA_W];
    assign ustrm_dvalid    = u_ctl.dvalid;
    assign ustrm_crc       = u_ctl.crc;
    assign ustrm_crc_valid = u_ctl.crc_valid;
    assign ustrm_valid     = u_ctl.valid;

endmodule

// File: tb/tb_lpif_txrx_asym_gearbox.sv
// Randomized bench for lpif_txrx_asym_gearbox against a queue-based reference model.
module tb_lpif_txrx_asym_gearbox;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ASYM   = 2;
    localparam int unsigned FLIT_W = 75;
`ifdef LPIF_GEARBOX_PARITY_EN
    localparam int unsigned SLOT_W = FLIT_W + 1;
`else
    localparam int unsigned SLOT_W = FLIT_W;
`endif
    localparam int unsigned WORD_W = SLOT_W * ASYM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_wr_n;
    logic              s_gen2, s_dv, s_flush, s_dvalid, s_crcv, s_rx_vld;
    logic [3:0]        s_state;
    logic [1:0]        s_protid, s_crc;
    logic [63:0]       s_data;
    logic [WORD_W-1:0] s_rx_word;

    logic [WORD_W-1:0] tx_data;
    logic              tx_vld, rx_rdy;
    logic [3:0]        u_state;
    logic [1:0]        u_protid, u_crc;
    logic [63:0]       u_data;
    logic              u_dvalid, u_crcv, u_valid;
`ifdef LPIF_GEARBOX_PARITY_EN
    logic              par_err;
`endif

    lpif_txrx_asym_gearbox #(.DATA_W(DATA_W), .ASYM_RATIO(ASYM)) dut (
        .clk_wr                 (clk),
        .rst_wr_n               (rst_wr_n),
        .m_gen2_mode            (s_gen2),
        .dstrm_state            (s_state),
        .dstrm_protid           (s_protid),
        .dstrm_data             (s_data),
        .dstrm_dvalid           (s_dvalid),
        .dstrm_crc              (s_crc),
        .dstrm_crc_valid        (s_crcv),
        .dstrm_valid            (s_dv),
        .tx_flush               (s_flush),
        .txfifo_downstream_data (tx_data),
        .txfifo_downstream_vld  (tx_vld),
        .rxfifo_upstream_data   (s_rx_word),
        .rxfifo_upstream_vld    (s_rx_vld),
        .rxfifo_upstream_rdy    (rx_rdy),
        .ustrm_state            (u_state),
        .ustrm_protid           (u_protid),
        .ustrm_data             (u_data),
        .ustrm_dvalid           (u_dvalid),
        .ustrm_crc              (u_crc),
        .ustrm_crc_valid        (u_crcv),
        .ustrm_valid            (u_valid)
`ifdef LPIF_GEARBOX_PARITY_EN
        ,
        .rx_parity_err          (par_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: pending TX flits, RX flits still to be replayed
    logic [FLIT_W-1:0] tx_q[$];
    logic [FLIT_W-1:0] rx_q[$];
    logic              prev_gen2;
    logic              m_chg, exp_rdy, exp_tx_vld, last_hs;
    logic [WORD_W-1:0] exp_tx_data;
    logic [FLIT_W-1:0] exp_u_flit;

    task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned eff_of(input logic g);
        if (g) return ASYM;
        return (ASYM >= 2) ? ASYM / 2 : 1;
    endfunction

    function automatic logic [SLOT_W-1:0] mk_slot(input logic [FLIT_W-1:0] f);
`ifdef LPIF_GEARBOX_PARITY_EN
        return {^f, f};
`else
        return f;
`endif
    endfunction

    // Slot layout from LSB: state 4, protid 2, data 64, dvalid, crc 2, crc_valid, valid
    function automatic logic [FLIT_W-1:0] in_flit();
        return {s_dv, s_crcv, s_crc, s_dvalid, s_data, s_protid, s_state};
    endfunction

    function automatic logic [FLIT_W-1:0] out_flit();
        return {u_valid, u_crcv, u_crc, u_dvalid, u_data, u_protid, u_state};
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        prev_gen2   = 1'b0;
        exp_tx_vld  = 1'b0;
        exp_tx_data = '0;
        exp_u_flit  = '0;
    endtask

    task automatic model_step();
        int unsigned eff;
        eff = eff_of(s_gen2);
        prev_gen2  = s_gen2;
        exp_tx_vld = 1'b0;
        if (m_chg) tx_q.delete();
        else begin
            if (s_dv) tx_q.push_back(in_flit());
            if (tx_q.size() == int'(eff) || (s_flush && tx_q.size() != 0)) begin
                exp_tx_data = '0;
                foreach (tx_q[i]) exp_tx_data[i*SLOT_W +: SLOT_W] = mk_slot(tx_q[i]);
                exp_tx_vld = 1'b1;
                tx_q.delete();
            end
        end
        exp_u_flit[FLIT_W-1] = 1'b0;
        if (m_chg) rx_q.delete();
        else begin
            if (rx_q.size() != 0) exp_u_flit = rx_q.pop_front();
            if (exp_rdy && s_rx_vld)
                for (int k = 0; k < int'(eff); k++) rx_q.push_back(s_rx_word[k*SLOT_W +: FLIT_W]);
        end
    endtask

    // One clock: inputs are already set; check rdy, advance model, check registered outputs
    task automatic cycle();
        #1;
        m_chg   = (s_gen2 != prev_gen2) && (tx_q.size() != 0 || rx_q.size() != 0);
        exp_rdy = !m_chg && (rx_q.size() <= 1);
        check("rx_rdy", WORD_W'(rx_rdy), WORD_W'(exp_rdy));
        last_hs = exp_rdy && s_rx_vld;
        model_step();
        @(posedge clk);
        #1;
        check("tx_vld", WORD_W'(tx_vld), WORD_W'(exp_tx_vld));
        check("tx_data", tx_data, exp_tx_data);
        check("ustrm", WORD_W'(out_flit()), WORD_W'(exp_u_flit));
    endtask

    task automatic idle_inputs();
        s_dv = 0; s_flush = 0; s_rx_vld = 0; s_state = '0; s_protid = '0;
        s_crc = '0; s_dvalid = 0; s_crcv = 0; s_data = '0; s_rx_word = '0;
    endtask

    task automatic set_flit(input logic [63:0] d);
        s_dv = 1; s_data = d;
    endtask

    task automatic do_reset();
        rst_wr_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_wr_n = 1'b1;
        model_reset();
        #1;
        check("rst_tx_data", tx_data, '0);
        check("rst_tx_vld", WORD_W'(tx_vld), '0);
        check("rst_ustrm", WORD_W'(out_flit()), '0);
        check("rst_rdy", WORD_W'(rx_rdy), WORD_W'(1));
`ifdef LPIF_GEARBOX_PARITY_EN
        check("rst_par_err", WORD_W'(par_err), '0);
`endif
    endtask

    function automatic logic [FLIT_W-1:0] data_flit(input logic [63:0] d);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[6 +: 64]     = d;
        f[FLIT_W-1]    = 1'b1;
        return f;
    endfunction

    initial begin
        logic [WORD_W-1:0] w[2];
        logic [63:0]       seen[$];
        int                idx, vld_cnt, first_c, last_c;
        logic [WORD_W-1:0] held;

        s_gen2 = 0;
        do_reset();

`ifdef LPIF_GEARBOX_PARITY_EN
        // Corrupt bit 10 of slot 0 and expect a sticky parity error
        begin
            logic [SLOT_W-1:0] bad_slot;
            bad_slot = mk_slot(data_flit(64'h11));
            bad_slot[10] = ~bad_slot[10];
            s_gen2 = 1; cycle();
            s_rx_word = {mk_slot(data_flit(64'h22)), bad_slot};
            s_rx_vld = 1; cycle();
            s_rx_vld = 0;
            check("par_before", WORD_W'(par_err), '0);
            cycle(); cycle();
            check("par_set", WORD_W'(par_err), WORD_W'(1));
            repeat (3) cycle();
            check("par_sticky", WORD_W'(par_err), WORD_W'(1));
            do_reset();
        end
`endif

        // Two flits in gen2 form one word
        s_gen2 = 1; cycle();
        set_flit(64'hA); cycle();
        check("t1_no_early", WORD_W'(tx_vld), '0);
        set_flit(64'hB); cycle();
        s_dv = 0;
        check("t1_vld", WORD_W'(tx_vld), WORD_W'(1));
        check("t1_slot0", WORD_W'(tx_data[6 +: 64]), WORD_W'(64'hA));
        check("t1_slot1", WORD_W'(tx_data[SLOT_W+6 +: 64]), WORD_W'(64'hB));
        cycle();
        check("t1_pulse", WORD_W'(tx_vld), '0);

        // Non-gen2: one flit per word, upper slot zero
        s_gen2 = 0; cycle();
        set_flit(64'h5); cycle();
        s_dv = 0;
        check("t2_vld", WORD_W'(tx_vld), WORD_W'(1));
        check("t2_upper", WORD_W'(tx_data[WORD_W-1:SLOT_W]), '0);
        set_flit(64'h6); cycle();
        s_dv = 0;
        check("t2_vld2", WORD_W'(tx_vld), WORD_W'(1));

        // Partial word flushed three cycles later
        s_gen2 = 1; cycle();
        set_flit(64'h7); cycle();
        s_dv = 0;
        repeat (2) cycle();
        s_flush = 1; cycle();
        s_flush = 0;
        check("t3_vld", WORD_W'(tx_vld), WORD_W'(1));
        check("t3_slot0", WORD_W'(tx_data[6 +: 64]), WORD_W'(64'h7));
        check("t3_slot1", WORD_W'(tx_data[WORD_W-1:SLOT_W]), '0);
        set_flit(64'h8); cycle();
        s_dv = 0;
        check("t3_cnt0", WORD_W'(tx_vld), '0);
        s_flush = 1; cycle();
        s_flush = 0;

        // Back-to-back RX words replay on consecutive cycles
        w[0] = {mk_slot(data_flit(64'd2)), mk_slot(data_flit(64'd1))};
        w[1] = {mk_slot(data_flit(64'd4)), mk_slot(data_flit(64'd3))};
        idx = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 8; c++) begin
            s_rx_vld = (idx < 2);
            if (idx < 2) s_rx_word = w[idx];
            cycle();
            if (last_hs) idx++;
            if (u_valid) begin
                seen.push_back(u_data);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        s_rx_vld = 0;
        check("t4_count", WORD_W'(seen.size()), WORD_W'(4));
        check("t4_span", WORD_W'(last_c - first_c), WORD_W'(3));
        foreach (seen[i]) check("t4_data", WORD_W'(seen[i]), WORD_W'(i + 1));

        // Mode toggle drops the partial word; only the new pair is emitted
        set_flit(64'hC1); cycle();
        s_dv = 0; s_gen2 = 0; cycle();
        s_gen2 = 1; cycle();
        vld_cnt = 0; held = '0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_flit(64'hD1);
            else if (c == 1) set_flit(64'hD2);
            else s_dv = 0;
            cycle();
            if (tx_vld) begin vld_cnt++; held = tx_data; end
        end
        check("t5_count", WORD_W'(vld_cnt), WORD_W'(1));
        check("t5_slot0", WORD_W'(held[6 +: 64]), WORD_W'(64'hD1));
        check("t5_slot1", WORD_W'(held[SLOT_W+6 +: 64]), WORD_W'(64'hD2));

        // Randomized traffic on both paths
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) s_gen2 = ~s_gen2;
            s_dv      = ($urandom_range(0, 99) < 60);
            s_flush   = ($urandom_range(0, 9) == 0);
            s_state   = 4'($urandom);
            s_protid  = 2'($urandom);
            s_crc     = 2'($urandom);
            s_dvalid  = 1'($urandom);
            s_crcv    = 1'($urandom);
            s_data    = {$urandom, $urandom};
            s_rx_vld  = 1'($urandom);
            for (int k = 0; k < WORD_W; k += 32) s_rx_word[k +: 32] = WORD_W'($urandom) << 0 >> 0 != 0 ? 32'($urandom) : 32'($urandom);
            cycle();
        end

        // Reset in the middle of a word drops everything at once
        idle_inputs(); s_gen2 = 1; cycle();
        set_flit(64'hE1); s_rx_vld = 1; s_rx_word = w[0]; cycle();
        idle_inputs(); cycle();
        rst_wr_n = 1'b0;
        #1;
        check("mid_rst_ustrm", WORD_W'(out_flit()), '0);
        check("mid_rst_tx", tx_data, '0);
        do_reset();
        set_flit(64'hE2); cycle();
        s_dv = 0;
        check("mid_rst_cnt", WORD_W'(tx_vld), '0);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpif_txrx_asym_gearbox.md
Name: lpif_txrx_asym_gearbox

Overview:
Parametrised successor to the fixed-width LPIF flit packer. Packs ASYM_RATIO consecutive valid LPIF downstream flits into one wide logic-link TX FIFO word, and unpacks each wide RX FIFO word into sequential upstream LPIF flits. Sits between the LPIF adapter and the AIB logic-link FIFOs. The effective ratio follows m_gen2_mode.

Parameters:
- DATA_W, 64, LPIF data field width per flit.
- ASYM_RATIO, 2, flits per FIFO word in gen2 mode; legal values 1, 2, 4.
- FLIT_W, DATA_W+11, bits per flit slot: state 4, protid 2, data DATA_W, dvalid 1, crc 2, crc_valid 1, valid 1.
- WORD_W, FLIT_W*ASYM_RATIO, FIFO word width; becomes (FLIT_W+1)*ASYM_RATIO with the optional feature.

Ports:
- clk_wr  in  1  single block clock.
- rst_wr_n  in  1  asynchronous active-low reset.
- m_gen2_mode  in  1  1: eff_ratio = ASYM_RATIO; 0: eff_ratio = max(ASYM_RATIO/2, 1).
- dstrm_state/protid/data/dvalid/crc/crc_valid/valid  in  4/2/DATA_W/1/2/1/1  downstream flit.
- tx_flush  in  1  pulse; emits any partial TX word.
- txfifo_downstream_data  out  WORD_W  packed word.
- txfifo_downstream_vld  out  1  one-cycle push strobe.
- rxfifo_upstream_data  in  WORD_W  received word.
- rxfifo_upstream_vld  in  1  word available.
- rxfifo_upstream_rdy  out  1  pop; a word is transferred when vld&rdy.
- ustrm_state/protid/data/dvalid/crc/crc_valid/valid  out  as dstrm  upstream flit, registered.
- rx_parity_err  out  1  sticky; present only with the optional feature.

Behaviour:
- Reset: every output is 0, both slot counters are 0, and the RX buffer is empty.
- Slot packing:
  - Slot k occupies bits [k*FLIT_W +: FLIT_W].
  - Within a slot, fields are packed LSB-first in the order state, protid, data, dvalid, crc, crc_valid, valid.
  - Slots at or above eff_ratio are driven to 0.
- TX path:
  - When dstrm_valid=1, the flit is written into slot tx_cnt and tx_cnt increments.
  - When the last slot (tx_cnt = eff_ratio-1) is written, the complete word is registered onto txfifo_downstream_data and vld=1 on the next cycle. Latency is 1 cycle. tx_cnt wraps to 0.
  - Cycles with dstrm_valid=0 do not advance tx_cnt.
  - vld is a single-cycle pulse; data holds its last value while vld=0.
  - tx_flush with tx_cnt>0: the partial word is emitted next cycle with unfilled slots all-0 (valid bit 0), and tx_cnt is set to 0.
  - tx_flush with tx_cnt=0: no effect.
  - tx_flush in the same cycle as dstrm_valid: the flit is included first, then the word is emitted.
  - There is no TX backpressure; the logic-link FIFO always accepts.
- RX path:
  - States are IDLE and UNPACK.
  - In IDLE, rdy=1. When vld=1, the word is captured, rx_cnt is set to 0, and the state goes to UNPACK.
  - In UNPACK, slot rx_cnt is registered onto the ustrm_* outputs each cycle and rx_cnt increments.
  - rdy=1 in the cycle rx_cnt = eff_ratio-1, so a back-to-back word is captured with no bubble. Otherwise the state returns to IDLE.
  - Timing: word captured at cycle N; slot k appears on ustrm at cycle N+1+k.
  - In IDLE (no slot being output), ustrm_valid=0 and the other ustrm fields hold their values.
  - A slot whose valid bit is 0 is still output for one cycle, with ustrm_valid=0.
- m_gen2_mode change while tx_cnt>0 or in UNPACK:
  - The partial TX word is discarded and tx_cnt is set to 0.
  - The RX word in progress is abandoned and the state returns to IDLE.
  - This mode-change condition takes priority over all other events in that cycle.
- Reset asserted mid-word: partial state is dropped immediately, with no emission.

Optional Feature:
- LPIF_GEARBOX_PARITY_EN defined:
  - Each slot carries one extra MSB holding the even parity of its FLIT_W bits.
  - RX checks parity on every slot output during UNPACK. Any mismatch sets rx_parity_err, which is cleared only by reset.
- Undefined: there is no parity bit, WORD_W = FLIT_W*ASYM_RATIO, and the rx_parity_err port is absent.

Decomposition:
- Package lpif_gearbox_pkg holds:
  - field width and offset localparams: STATE_W=4, PROTID_W=2, CRC_W=2, and the offsets;
  - a typedef for the flit struct;
  - the function eff_ratio(gen2).
- One sub-module, lpif_gearbox_rx_unpack, holds the RX FSM, rx_cnt and the buffer. The TX packing stays in the top module.

Test Plan:
All scenarios use DATA_W=64, ASYM_RATIO=2, FLIT_W=75, WORD_W=150.
1. gen2=1: drive dstrm_valid for 2 cycles with data 0xA, then 0xB. Expect one vld pulse 1 cycle later, with data[6+:64]=0xA and data[81+:64]=0xB.
2. gen2=0: each valid flit produces a vld pulse one cycle later, with the upper 75 bits all 0.
3. One valid flit, then tx_flush 3 cycles later. Expect vld 1 cycle after the flush, with slot1 all 0 and tx_cnt=0.
4. RX: rxfifo_upstream_vld held high with two words, slots 0x1, 0x2, 0x3, 0x4. Expect ustrm_data to show 1, 2, 3, 4 on consecutive cycles and rdy pulsing every other cycle.
5. Toggle m_gen2_mode after one TX flit, then drive 2 flits. Expect only the new 2-flit word to be emitted.
6. LPIF_GEARBOX_PARITY_EN: flip bit 10 of an RX slot. Expect rx_parity_err=1 from the cycle after that slot is output, staying high until rst_wr_n=0.
